// File: rtl/jpeg_rom_fetch.sv
// jpeg_rom_fetch: walks a JPEG byte stream in ROM, unstuffs FF00, skips fill bytes, flags markers; ports: clk/rst, start+start_addr, rom_addr/rom_rd_en/rom_data, byte_out/byte_valid/marker_valid/byte_ready, busy/done/err
module jpeg_rom_fetch #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            rom_data,
  input  logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd_en,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic                  marker_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FF_SEEN, S_HOLD, S_DONE} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_byte;
  logic                  r_bv, r_mv, r_err, r_last;
  logic                  w_max, w_ff, w_sample;
  assign w_max     = &r_addr;
  assign w_ff      = rom_data == 8'hFF;
  assign w_sample  = r_state == S_FETCH || r_state == S_FF_SEEN;
  assign rom_addr     = r_addr;
  assign rom_rd_en    = w_sample;
  assign byte_out     = r_byte;
  assign byte_valid   = r_bv;
  assign marker_valid = r_mv;
  assign busy         = r_state != S_IDLE;
  assign done         = r_state == S_DONE;
  assign err          = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_byte  <= '0;
      r_bv    <= 1'b0;
      r_mv    <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_addr  <= start_addr;
          r_err   <= 1'b0;
          r_state <= S_FETCH;
        end
        S_FETCH, S_FF_SEEN: begin
          // saturate at the top of ROM; r_last remembers that this sample was the final address
          r_addr <= w_max ? r_addr : r_addr + 1'b1;
          r_last <= w_max;
          if (w_ff) begin
            // an FF with nothing after it is a truncated marker
            r_err   <= r_err | w_max;
            r_state <= w_max ? S_DONE : S_FF_SEEN;
          end else if (r_state == S_FETCH || rom_data == 8'h00) begin
            r_byte  <= r_state == S_FETCH ? rom_data : 8'hFF;
            r_bv    <= 1'b1;
            r_state <= S_HOLD;
          end else begin
            r_byte  <= rom_data;
            r_mv    <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: if (byte_ready) begin
          r_bv    <= 1'b0;
          r_mv    <= 1'b0;
          r_state <= (r_mv && r_byte == 8'hD9) || r_last ? S_DONE : S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/jpeg_rom_fetch.md
JPEG_ROM_FETCH -- requirements
Module: jpeg_rom_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the ROM address width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin fetching; sampled in IDLE only.
REQ-005 SHALL have port start_addr  input  ADDR_WIDTH  first ROM address, captured with start.
REQ-006 SHALL have port rom_data  input  8  ROM read data, combinational from rom_addr in the same cycle.
REQ-007 SHALL have port byte_ready  input  1  downstream accepts the output this cycle.
REQ-008 SHALL have port rom_addr  output  ADDR_WIDTH  ROM address.
REQ-009 SHALL have port rom_rd_en  output  1  high in cycles where rom_data is sampled.
REQ-010 SHALL have port byte_out  output  8  data byte or marker code.
REQ-011 SHALL have port byte_valid  output  1  byte_out holds an entropy/header data byte.
REQ-012 SHALL have port marker_valid  output  1  byte_out holds a marker code, the byte following 0xFF.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of fetch.
REQ-015 SHALL have port err  output  1  truncated-marker flag; held until next accepted start or rst.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, FF_SEEN, HOLD, DONE.
REQ-017 IDLE: start=1 SHALL load rom_addr<=start_addr, clear err, go FETCH; start is ignored in all other states.
REQ-018 FETCH/FF_SEEN SHALL drive rom_rd_en=1 and sample rom_data at the current rom_addr.
REQ-019 FETCH, rom_data!=0xFF: SHALL register byte_out<=rom_data, byte_valid<=1, go HOLD.
REQ-020 FETCH, rom_data==0xFF: SHALL go FF_SEEN with no output.
REQ-021 FF_SEEN, rom_data==0x00 (stuffed byte): SHALL emit byte_out=0xFF with byte_valid=1, go HOLD.
REQ-022 FF_SEEN, rom_data==0xFF (fill byte): SHALL remain in FF_SEEN with no output.
REQ-023 FF_SEEN, any other value: SHALL emit byte_out=rom_data with marker_valid=1, go HOLD.
REQ-024 After every sample cycle, rom_addr SHALL increment by 1 unless it equals all-ones; it SHALL saturate and never wrap.
REQ-025 HOLD SHALL keep byte_out, byte_valid and marker_valid stable until byte_ready=1; on that cycle both valids SHALL clear.
REQ-026 On acceptance in HOLD, next state SHALL be DONE if the output was marker 0xD9 (EOI) or the last sample was at address all-ones; otherwise FETCH.
REQ-027 byte_valid and marker_valid SHALL never be high simultaneously.
REQ-028 A sampled 0xFF at address all-ones (FETCH or FF_SEEN) SHALL set err=1 and go DONE with no output.
REQ-029 DONE SHALL assert done=1 for exactly one cycle, then go IDLE; busy=1 in DONE.
REQ-030 Throughput SHALL be one output per two cycles with byte_ready held high; there is no other latency beyond REQ-019..023.

Reset
REQ-031 rst=1 SHALL force IDLE, rom_addr=0, byte_out=0, byte_valid=0, marker_valid=0, rom_rd_en=0, busy=0, done=0, err=0.
REQ-032 rst SHALL take priority over start and byte_ready; reset mid-fetch SHALL drop any pending output with no done pulse.

Verification
REQ-033 ROM 0x10:{12,34,FF,D9}, start_addr=0x10, byte_ready=1 -> byte_valid 0x12, byte_valid 0x34, marker_valid 0xD9, done pulse, rom_addr=0x14, err=0.
REQ-034 ROM {FF,00,FF,FF,FF,C4} -> byte_valid 0xFF, then marker_valid 0xC4; no output for the fill bytes.
REQ-035 byte_ready=0 for 5 cycles while byte 0xAB is pending -> byte_out=0xAB and byte_valid held all 5 cycles; rom_addr and rom_rd_en static (rom_rd_en=0).
REQ-036 start_addr=all-ones, ROM[all-ones]=0x55 -> byte_valid 0x55, done pulse, rom_addr stays all-ones; ROM[all-ones]=0xFF instead -> no output, err=1, done pulse.
REQ-037 rst asserted in HOLD with valid pending -> next cycle all outputs 0, IDLE; start asserted while busy -> no effect on rom_addr.
